// File: rtl/cfs_algn_ctrl.sv
// Byte aligner: packs RX bytes from arbitrary lanes into a 2B-byte FIFO and
// emits TX transfers of the configured size/offset.
module cfs_algn_ctrl #(
    parameter  int unsigned ALGN_DATA_WIDTH = 32,
    localparam int unsigned B               = ALGN_DATA_WIDTH / 8,
    localparam int unsigned OW              = $clog2(B)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    input  logic [ALGN_DATA_WIDTH-1:0] rx_data,
    input  logic [OW-1:0]              rx_offset,
    input  logic [OW:0]                rx_size,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [ALGN_DATA_WIDTH-1:0] tx_data,
    output logic [OW-1:0]              tx_offset,
    output logic [OW:0]                tx_size,
    input  logic [OW:0]                ctrl_size,
    input  logic [OW-1:0]              ctrl_offset,
    input  logic                       ctrl_clr,
    output logic                       rx_drop,
    output logic [OW+1:0]              status_level
);

    localparam int unsigned DW = ALGN_DATA_WIDTH;
    localparam int unsigned LW = OW + 2;
    localparam int unsigned BW = OW + 1;
    localparam int unsigned NB = 2 * B;

    typedef enum logic {
        IDLE    = 1'b0,
        TX_WAIT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     buf_q [NB];
    logic [7:0]     buf_d [NB];
    logic [7:0]     rx_bytes [B];
    logic [LW-1:0]  level_q, level_d;
    logic [LW-1:0]  pop_n, base;
    logic [DW-1:0]  tx_data_q, tx_data_d;
    logic [OW-1:0]  tx_offset_q, tx_offset_d;
    logic [OW:0]    tx_size_q, tx_size_d;
    logic           rx_drop_q, rx_drop_d;
    logic           rx_hs, rx_legal, cfg_legal, pop;

    assign rx_legal  = (rx_size != '0) && ((LW'(rx_offset) + LW'(rx_size)) <= LW'(B));
    assign cfg_legal = (ctrl_size != '0) && ((LW'(ctrl_offset) + LW'(ctrl_size)) <= LW'(B));
    assign rx_ready  = (level_q <= LW'(B)) && !ctrl_clr;
    assign rx_hs     = rx_valid && rx_ready;

    always_comb begin
        for (int k = 0; k < B; k++) begin
            rx_bytes[k] = rx_data[k*8 +: 8];
        end
    end

    // Next state and TX payload capture; clear overrides everything
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_offset_d = tx_offset_q;
        tx_size_d   = tx_size_q;
        pop         = 1'b0;
        if (ctrl_clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_legal && (level_q >= LW'(ctrl_size))) begin
                        state_d     = TX_WAIT;
                        tx_offset_d = ctrl_offset;
                        tx_size_d   = ctrl_size;
                        for (int l = 0; l < B; l++) begin
                            if ((32'(l) >= 32'(ctrl_offset)) &&
                                (32'(l) < 32'(ctrl_offset) + 32'(ctrl_size))) begin
                                tx_data_d[l*8 +: 8] = buf_q[BW'(32'(l) - 32'(ctrl_offset))];
                            end else begin
                                tx_data_d[l*8 +: 8] = 8'h00;
                            end
                        end
                    end
                end
                TX_WAIT: begin
                    if (tx_ready) begin
                        state_d = IDLE;
                        pop     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO: shift out popped bytes, then append compacted RX bytes behind the survivors
    always_comb begin
        pop_n = pop ? LW'(tx_size_q) : '0;
        base  = level_q - pop_n;
        for (int i = 0; i < NB; i++) begin
            if ((32'(i) + 32'(pop_n)) < NB) begin
                buf_d[i] = buf_q[BW'(32'(i) + 32'(pop_n))];
            end else begin
                buf_d[i] = 8'h00;
            end
        end
        if (rx_hs && rx_legal) begin
            for (int j = 0; j < B; j++) begin
                if (32'(j) < 32'(rx_size)) begin
                    buf_d[BW'(32'(base) + 32'(j))] = rx_bytes[OW'(32'(rx_offset) + 32'(j))];
                end
            end
        end
        level_d = base + ((rx_hs && rx_legal) ? LW'(rx_size) : '0);
        if (ctrl_clr) begin
            level_d = '0;
        end
        rx_drop_d = rx_hs && !rx_legal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            level_q     <= '0;
            tx_data_q   <= '0;
            tx_offset_q <= '0;
            tx_size_q   <= '0;
            rx_drop_q   <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            tx_data_q   <= tx_data_d;
            tx_offset_q <= tx_offset_d;
            tx_size_q   <= tx_size_d;
            rx_drop_q   <= rx_drop_d;
            for (int i = 0; i < NB; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign tx_valid     = (state_q == TX_WAIT);
    assign tx_data      = tx_data_q;
    assign tx_offset    = tx_offset_q;
    assign tx_size      = tx_size_q;
    assign rx_drop      = rx_drop_q;
    assign status_level = level_q;

endmodule

// File: tb/tb_cfs_algn_ctrl.sv
// Randomized and directed bench for cfs_algn_ctrl (B=4) against a byte-queue reference model.
module tb_cfs_algn_ctrl;

    localparam int DW = 32;
    localparam int B  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_valid, rx_ready, tx_valid, tx_ready, ctrl_clr, rx_drop;
    logic [DW-1:0] rx_data, tx_data;
    logic [1:0]    rx_offset, tx_offset, ctrl_offset;
    logic [2:0]    rx_size, tx_size, ctrl_size;
    logic [3:0]    status_level;

    always #5 clk = ~clk;

    cfs_algn_ctrl #(.ALGN_DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_offset(rx_offset), .rx_size(rx_size),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_offset(tx_offset), .tx_size(tx_size),
        .ctrl_size(ctrl_size), .ctrl_offset(ctrl_offset), .ctrl_clr(ctrl_clr),
        .rx_drop(rx_drop), .status_level(status_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered bytes oldest-first, plus the pending TX transfer
    byte unsigned mq[$];
    logic         m_valid = 1'b0;
    logic         m_drop  = 1'b0;
    logic [31:0]  m_data  = '0;
    int           m_off   = 0;
    int           m_size  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ready, hs, legal;
        ready = (mq.size() <= B) && !ctrl_clr;
        if (ctrl_clr) begin
            mq.delete();
            m_valid = 1'b0;
            m_drop  = 1'b0;
            return;
        end
        hs     = rx_valid && ready;
        legal  = (rx_size != 0) && (int'(rx_offset) + int'(rx_size) <= B);
        m_drop = hs && !legal;
        if (m_valid) begin
            if (tx_ready) begin
                repeat (m_size) void'(mq.pop_front());
                m_valid = 1'b0;
            end
        end else if ((ctrl_size != 0) && (int'(ctrl_offset) + int'(ctrl_size) <= B) &&
                     (mq.size() >= int'(ctrl_size))) begin
            m_data = '0;
            for (int k = 0; k < int'(ctrl_size); k++) begin
                m_data[(int'(ctrl_offset) + k)*8 +: 8] = mq[k];
            end
            m_off   = int'(ctrl_offset);
            m_size  = int'(ctrl_size);
            m_valid = 1'b1;
        end
        if (hs && legal) begin
            for (int k = 0; k < int'(rx_size); k++) begin
                mq.push_back(rx_data[(int'(rx_offset) + k)*8 +: 8]);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("tx_valid", 64'(tx_valid), 64'(m_valid));
        check_eq("status_level", 64'(status_level), 64'(mq.size()));
        check_eq("rx_ready", 64'(rx_ready), 64'((mq.size() <= B) && !ctrl_clr));
        check_eq("rx_drop", 64'(rx_drop), 64'(m_drop));
        if (m_valid) begin
            check_eq("tx_data", 64'(tx_data), 64'(m_data));
            check_eq("tx_offset", 64'(tx_offset), 64'(m_off));
            check_eq("tx_size", 64'(tx_size), 64'(m_size));
        end
    endtask

    // One clock: model consumes current inputs, DUT clocks, outputs compared on the falling edge
    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_rx(input logic [31:0] d, input int off, input int sz);
        rx_valid  = 1'b1;
        rx_data   = d;
        rx_offset = 2'(off);
        rx_size   = 3'(sz);
        step();
        rx_valid  = 1'b0;
    endtask

    task automatic clear();
        ctrl_clr = 1'b1;
        step();
        ctrl_clr = 1'b0;
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_valid && n < 10) begin
            step();
            n++;
        end
        if (!tx_valid) check_eq("tx_timeout", 64'(tx_valid), 64'(1));
    endtask

    initial begin
        reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_offset = '0; rx_size = '0;
        tx_ready = 1'b0; ctrl_size = 3'd4; ctrl_offset = '0; ctrl_clr = 1'b0;
        #1;
        check_eq("rst_tx_valid", 64'(tx_valid), 64'(0));
        check_eq("rst_level", 64'(status_level), 64'(0));
        check_eq("rst_rx_ready", 64'(rx_ready), 64'(1));
        check_eq("rst_tx_data", 64'(tx_data), 64'(0));
        check_eq("rst_rx_drop", 64'(rx_drop), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Pack four single-byte transfers, including the 2-cycle latency
        clear();
        ctrl_size = 3'd4; ctrl_offset = 2'd0; tx_ready = 1'b1;
        send_rx(32'h000000AA, 0, 1);
        send_rx(32'h0000BB00, 1, 1);
        send_rx(32'h00CC0000, 2, 1);
        send_rx(32'hDD000000, 3, 1);
        check_eq("pack_lat1", 64'(tx_valid), 64'(0));
        step();
        check_eq("pack_lat2", 64'(tx_valid), 64'(1));
        check_eq("pack_data", 64'(tx_data), 64'(32'hDDCCBBAA));
        check_eq("pack_size", 64'(tx_size), 64'(4));
        check_eq("pack_off", 64'(tx_offset), 64'(0));
        step();
        check_eq("pack_empty", 64'(status_level), 64'(0));

        // Split one word into two upper-half transfers
        clear();
        ctrl_size = 3'd2; ctrl_offset = 2'd2;
        send_rx(32'h44332211, 0, 4);
        wait_tx();
        check_eq("split_data0", 64'(tx_data), 64'(32'h22110000));
        check_eq("split_size0", 64'(tx_size), 64'(2));
        step();
        wait_tx();
        check_eq("split_data1", 64'(tx_data), 64'(32'h44330000));
        check_eq("split_off1", 64'(tx_offset), 64'(2));
        step();
        check_eq("split_empty", 64'(status_level), 64'(0));

        // Illegal RX transfer is consumed and dropped
        clear();
        ctrl_size = 3'd4; ctrl_offset = 2'd0;
        send_rx(32'h12345678, 2, 3);
        check_eq("ill_drop", 64'(rx_drop), 64'(1));
        check_eq("ill_level", 64'(status_level), 64'(0));
        step();
        check_eq("ill_drop_end", 64'(rx_drop), 64'(0));
        check_eq("ill_no_tx", 64'(tx_valid), 64'(0));

        // Backpressure fills the buffer to 2B
        clear();
        tx_ready = 1'b0;
        rx_valid = 1'b1; rx_offset = 2'd0; rx_size = 3'd4;
        repeat (6) begin
            rx_data = $urandom;
            step();
        end
        rx_valid = 1'b0;
        check_eq("bp_level8", 64'(status_level), 64'(8));
        check_eq("bp_ready0", 64'(rx_ready), 64'(0));
        check_eq("bp_valid", 64'(tx_valid), 64'(1));
        tx_ready = 1'b1;
        step();
        check_eq("bp_level4", 64'(status_level), 64'(4));
        wait_tx();
        step();
        check_eq("bp_level0", 64'(status_level), 64'(0));

        // Clear during TX_WAIT with a competing RX transfer
        ctrl_size = 3'd2; tx_ready = 1'b0;
        send_rx(32'h01020304, 0, 4);
        wait_tx();
        ctrl_clr = 1'b1; rx_valid = 1'b1; rx_data = 32'hCAFEF00D; rx_size = 3'd4; rx_offset = 2'd0;
        #1;
        check_eq("clr_ready0", 64'(rx_ready), 64'(0));
        step();
        check_eq("clr_valid", 64'(tx_valid), 64'(0));
        check_eq("clr_level", 64'(status_level), 64'(0));
        ctrl_clr = 1'b0; rx_valid = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 4) == 0) begin
                    ctrl_size   = 3'($urandom_range(0, 4));
                    ctrl_offset = 2'($urandom_range(0, 3));
                end else begin
                    ctrl_size   = 3'($urandom_range(1, 4));
                    ctrl_offset = 2'($urandom_range(0, 4 - int'(ctrl_size)));
                end
            end
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                rx_size   = 3'($urandom_range(0, 4));
                rx_offset = 2'($urandom_range(0, 3));
            end else begin
                rx_size   = 3'($urandom_range(1, 4));
                rx_offset = 2'($urandom_range(0, 4 - int'(rx_size)));
            end
            tx_ready = ($urandom_range(0, 9) < 6);
            ctrl_clr = ($urandom_range(0, 59) == 0);
            step();
        end
        rx_valid = 1'b0; ctrl_clr = 1'b0;

        // Asynchronous reset while a TX transfer is pending
        clear();
        ctrl_size = 3'd4; ctrl_offset = 2'd0; tx_ready = 1'b0;
        send_rx(32'h89ABCDEF, 0, 4);
        wait_tx();
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(tx_valid), 64'(0));
        check_eq("arst_level", 64'(status_level), 64'(0));
        check_eq("arst_ready", 64'(rx_ready), 64'(1));
        mq.delete();
        m_valid = 1'b0;
        m_drop  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfs_algn_ctrl.md
CFS_ALGN_CTRL -- requirements
Module: cfs_algn_ctrl

Interface
REQ-001 SHALL have parameter ALGN_DATA_WIDTH, default 32, RX/TX data width in bits (power of 2, >=16); B = ALGN_DATA_WIDTH/8 bytes; OW = log2(B).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports rx_valid input 1; rx_ready output 1; rx_data input ALGN_DATA_WIDTH; rx_offset input OW; rx_size input OW+1: RX transfer.
REQ-005 SHALL have ports tx_valid output 1; tx_ready input 1; tx_data output ALGN_DATA_WIDTH; tx_offset output OW; tx_size output OW+1: TX transfer.
REQ-006 SHALL have ports ctrl_size input OW+1; ctrl_offset input OW: configured TX size and offset.
REQ-007 SHALL have port ctrl_clr  input  1  single-cycle pulse that flushes buffered bytes.
REQ-008 SHALL have port rx_drop  output  1  registered one-cycle pulse per dropped illegal RX transfer.
REQ-009 SHALL have port status_level  output  OW+2  buffered byte count, 0..2B.

Function
REQ-010 SHALL treat an RX transfer as legal iff rx_size != 0 and rx_offset + rx_size <= B.
REQ-011 SHALL treat the configuration as legal iff ctrl_size != 0 and ctrl_offset + ctrl_size <= B; an illegal configuration never starts a TX transfer.
REQ-012 SHALL drive rx_ready = (status_level <= B) and not ctrl_clr, combinationally from registered state only.
REQ-013 On an RX handshake (rx_valid and rx_ready) with a legal transfer, SHALL append bytes from lanes rx_offset..rx_offset+rx_size-1 to a 2B-byte FIFO buffer, lowest lane first.
REQ-014 On an RX handshake with an illegal transfer, SHALL consume it, leave the buffer unchanged and assert rx_drop on the next cycle.
REQ-015 SHALL run an FSM with states IDLE and TX_WAIT; reset state IDLE.
REQ-016 IDLE -> TX_WAIT when status_level >= ctrl_size and the configuration is legal; on that edge SHALL register tx_offset=ctrl_offset, tx_size=ctrl_size and tx_data holding the oldest ctrl_size bytes in lanes ctrl_offset upward, oldest in the lowest lane, all other lanes zero.
REQ-017 SHALL assert tx_valid exactly while in TX_WAIT; tx_data/tx_offset/tx_size SHALL remain stable until the handshake, regardless of ctrl_size/ctrl_offset changes.
REQ-018 TX_WAIT -> IDLE on tx_valid and tx_ready; on that edge the buffer SHALL pop tx_size bytes.
REQ-019 When an RX append and a TX pop occur in the same cycle, status_level SHALL become level + appended - popped, with byte order preserved.
REQ-020 Latency: with tx_ready high, tx_valid SHALL assert 2 cycles after the RX handshake cycle that makes status_level >= ctrl_size, and no earlier.
REQ-021 ctrl_clr SHALL, on the next edge, set status_level=0, enter IDLE and deassert tx_valid; an RX transfer presented in the same cycle is not accepted (rx_ready=0); ctrl_clr takes priority over every other event.

Reset
REQ-022 While reset_n=0, SHALL asynchronously force: state IDLE, status_level=0, tx_valid=0, tx_data=0, tx_offset=0, tx_size=0, rx_drop=0; rx_ready is therefore 1.
REQ-023 SHALL release from reset on the first rising clk edge after reset_n deasserts, with no extra reset synchronisation in this block.

Verification (B=4)
REQ-024 Reset: assert reset_n=0 mid-TX_WAIT -> tx_valid=0, status_level=0, rx_ready=1 immediately, without waiting for a clock edge.
REQ-025 Pack: ctrl_size=4, ctrl_offset=0; four RX transfers, size 1, offsets 0,1,2,3, bytes AA,BB,CC,DD -> one TX transfer, tx_data=0xDDCCBBAA, size 4, offset 0.
REQ-026 Split: ctrl_size=2, ctrl_offset=2; one RX transfer, data 0x44332211, size 4, offset 0 -> TX 0x22110000 then 0x44330000, both size 2, offset 2.
REQ-027 Illegal: RX transfer with size 3, offset 2 -> accepted, rx_drop pulses 1 cycle, status_level unchanged, no TX.
REQ-028 Backpressure: ctrl_size=4; tx_ready=0 for 6 cycles while sending RX transfers of size 4 -> tx outputs stable, status_level reaches 8, rx_ready=0; then tx_ready=1 -> level drops 8->4->0.
REQ-029 Clear: ctrl_clr pulse during TX_WAIT, with a simultaneous RX transfer -> next cycle tx_valid=0, status_level=0, RX transfer not accepted.
